// File: rtl/ssd1306_spi_arbiter.sv
// ssd1306_spi_arbiter: shares one spi_master byte channel between the command
// sequencer (port C) and the pixel streamer (port P). Owns oled_dc, holds D/C
// stable before every write strobe, keeps bursts atomic, limits how long P can
// be starved, and abandons a transfer whose spi_done never arrives.
module ssd1306_spi_arbiter #(
  parameter int unsigned DC_SETUP    = 2,
  parameter int unsigned MAX_C_BURST = 4,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       c_req,
  input  logic [7:0] c_data,
  input  logic       c_dc,
  input  logic       c_last,
  output logic       c_ack,
  input  logic       p_req,
  input  logic [7:0] p_data,
  input  logic       p_dc,
  input  logic       p_last,
  output logic       p_ack,
  output logic [7:0] spi_data,
  output logic       spi_wr,
  input  logic       spi_done,
  output logic       oled_dc,
  output logic [1:0] grant,
  output logic       busy,
  output logic       err
);

  localparam int unsigned    TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  SETUP_LOAD = TW'(DC_SETUP - 1);
  localparam logic [TW-1:0]  WAIT_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [3:0]     C_LIMIT    = 4'(MAX_C_BURST);
  localparam logic [1:0]     G_NONE     = 2'b00;
  localparam logic [1:0]     G_C        = 2'b01;
  localparam logic [1:0]     G_P        = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_WRITE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [7:0]    spi_data_q, spi_data_d;
  logic          dc_q, dc_d;
  logic          last_q, last_d;
  logic          wreq_q, wreq_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cburst_q, cburst_d;

  logic          pick_c;
  logic          own_req;
  logic [7:0]    own_data;
  logic          own_dc;
  logic          own_last;

  // Current owner's request view, used when a burst continues after WAIT.
  always_comb begin
    own_req  = p_req;
    own_data = p_data;
    own_dc   = p_dc;
    own_last = p_last;
    if (grant_q == G_C) begin
      own_req  = c_req;
      own_data = c_data;
      own_dc   = c_dc;
      own_last = c_last;
    end
  end

  assign pick_c = c_req && (!p_req || (cburst_q < C_LIMIT));

  // Next-state logic. Byte, D/C and last are captured on the edge entering
  // LOAD so oled_dc already shows the new value during the LOAD/ack cycle.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    spi_data_d = spi_data_q;
    dc_d       = dc_q;
    last_d     = last_q;
    wreq_d     = wreq_q;
    timer_d    = timer_q;
    cburst_d   = cburst_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_c) begin
          state_d    = S_LOAD;
          grant_d    = G_C;
          spi_data_d = c_data;
          dc_d       = c_dc;
          last_d     = c_last;
        end else if (p_req) begin
          state_d    = S_LOAD;
          grant_d    = G_P;
          spi_data_d = p_data;
          dc_d       = p_dc;
          last_d     = p_last;
        end
      end
      S_LOAD: begin
        state_d = S_SETUP;
        timer_d = SETUP_LOAD;
      end
      S_SETUP: begin
        if (timer_q == '0) begin
          state_d = S_WRITE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_WAIT;
        timer_d = WAIT_LOAD;
        wreq_d  = 1'b0;
      end
      S_WAIT: begin
        if (wreq_q || spi_done) begin
          if (!wreq_q && last_q) begin
            state_d = S_IDLE;
            grant_d = G_NONE;
            if (grant_q == G_C && p_req) begin
              cburst_d = (cburst_q == '1) ? cburst_q : cburst_q + 1'b1;
            end else begin
              cburst_d = '0;
            end
          end else if (own_req) begin
            state_d    = S_LOAD;
            wreq_d     = 1'b0;
            spi_data_d = own_data;
            dc_d       = own_dc;
            last_d     = own_last;
          end else begin
            wreq_d = 1'b1;
          end
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
          grant_d = G_NONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = G_NONE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= G_NONE;
      spi_data_q <= '0;
      dc_q       <= 1'b0;
      last_q     <= 1'b0;
      wreq_q     <= 1'b0;
      timer_q    <= '0;
      cburst_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      spi_data_q <= spi_data_d;
      dc_q       <= dc_d;
      last_q     <= last_d;
      wreq_q     <= wreq_d;
      timer_q    <= timer_d;
      cburst_q   <= cburst_d;
    end
  end

  assign c_ack    = (state_q == S_LOAD) && (grant_q == G_C);
  assign p_ack    = (state_q == S_LOAD) && (grant_q == G_P);
  assign spi_wr   = (state_q == S_WRITE);
  assign busy     = (state_q != S_IDLE);
  assign err      = (state_q == S_WAIT) && !wreq_q && !spi_done && (timer_q == '0);
  assign spi_data = spi_data_q;
  assign oled_dc  = dc_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_ssd1306_spi_arbiter.sv
// Scoreboard bench for ssd1306_spi_arbiter: requester models feed C and P,
// a byte-level spi_master model answers writes, every write is checked
// against the byte the bench handed over.
module tb_ssd1306_spi_arbiter;

  localparam int unsigned DC_SETUP    = 2;
  localparam int unsigned MAX_C_BURST = 4;
  localparam int unsigned TIMEOUT     = 32;
  localparam int          SPI_LAT     = 3;

  logic       clk_50M, rst_n;
  logic       c_req, c_dc, c_last, c_ack;
  logic [7:0] c_data;
  logic       p_req, p_dc, p_last, p_ack;
  logic [7:0] p_data;
  logic [7:0] spi_data;
  logic       spi_wr, spi_done, oled_dc, busy, err;
  logic [1:0] grant;

  typedef struct packed { logic [7:0] d; logic dc; logic last; } req_t;
  typedef struct packed { logic [7:0] d; logic dc; logic [1:0] g; } exp_t;

  req_t       c_q[$];
  req_t       p_q[$];
  exp_t       sb[$];
  logic [1:0] gl[$];

  int n_chk, n_fail;
  int cyc, c_rise_cyc, c_ack_cyc, wr_cyc, wr_n, err_cyc, err_cnt, dc_chg_cyc;
  bit hang;

  ssd1306_spi_arbiter #(
    .DC_SETUP   (DC_SETUP),
    .MAX_C_BURST(MAX_C_BURST),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .c_req   (c_req),
    .c_data  (c_data),
    .c_dc    (c_dc),
    .c_last  (c_last),
    .c_ack   (c_ack),
    .p_req   (p_req),
    .p_data  (p_data),
    .p_dc    (p_dc),
    .p_last  (p_last),
    .p_ack   (p_ack),
    .spi_data(spi_data),
    .spi_wr  (spi_wr),
    .spi_done(spi_done),
    .oled_dc (oled_dc),
    .grant   (grant),
    .busy    (busy),
    .err     (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    clk_50M = 1'b0;
    forever #10 clk_50M = ~clk_50M;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk_50M);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // C requester: presents queued bytes, retires one on each c_ack.
  initial begin
    c_req = 1'b0; c_data = '0; c_dc = 1'b0; c_last = 1'b0;
    forever begin
      @(posedge clk_50M); #1;
      if (c_ack && c_q.size() > 0) begin
        sb.push_back({c_data, c_dc, 2'b01});
        void'(c_q.pop_front());
      end
      if (c_q.size() > 0) begin
        if (!c_req) c_rise_cyc = cyc;
        c_req = 1'b1;
        {c_data, c_dc, c_last} = c_q[0];
      end else begin
        c_req = 1'b0;
      end
    end
  end

  // P requester.
  initial begin
    p_req = 1'b0; p_data = '0; p_dc = 1'b0; p_last = 1'b0;
    forever begin
      @(posedge clk_50M); #1;
      if (p_ack && p_q.size() > 0) begin
        sb.push_back({p_data, p_dc, 2'b10});
        void'(p_q.pop_front());
      end
      if (p_q.size() > 0) begin
        p_req = 1'b1;
        {p_data, p_dc, p_last} = p_q[0];
      end else begin
        p_req = 1'b0;
      end
    end
  end

  // spi_master model plus write monitor.
  initial begin
    int   done_cnt;
    logic prev_dc;
    done_cnt = 0; prev_dc = 1'b0; spi_done = 1'b0;
    wr_n = 0; err_cnt = 0; dc_chg_cyc = 0;
    forever begin
      @(posedge clk_50M); #1;
      spi_done = 1'b0;
      if (!rst_n) begin
        done_cnt = 0;
        prev_dc  = oled_dc;
      end else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) spi_done = 1'b1;
        end
        if (oled_dc !== prev_dc) begin
          check_eq("dc_change_in_load", 32'(c_ack | p_ack), 32'd1);
          dc_chg_cyc = cyc;
        end
        prev_dc = oled_dc;
        if (c_ack) c_ack_cyc = cyc;
        if (err) begin
          err_cnt++;
          err_cyc = cyc;
        end
        if (spi_wr) begin
          exp_t e;
          wr_cyc = cyc;
          wr_n++;
          gl.push_back(grant);
          check_eq("dc_setup_time", 32'((cyc - dc_chg_cyc) >= int'(DC_SETUP)), 32'd1);
          check_eq("sb_has_entry", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("wr_data", 32'(spi_data), 32'(e.d));
            check_eq("wr_dc", 32'(oled_dc), 32'(e.dc));
            check_eq("wr_grant", 32'(grant), 32'(e.g));
          end
          if (!hang) done_cnt = SPI_LAT;
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk_50M);
      if (busy === 1'b0 && !c_req && !p_req && c_q.size() == 0 && p_q.size() == 0) done = 1'b1;
    end
    check_eq({tag, "_reached_idle"}, 32'(done), 32'd1);
    check_eq({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_grants(input string tag, input string s);
    check_eq({tag, "_grant_count"}, 32'(gl.size()), 32'(s.len()));
    for (int i = 0; i < s.len() && i < gl.size(); i++)
      check_eq({tag, "_grant_order"}, 32'(gl[i]), (s[i] == "C") ? 32'd1 : 32'd2);
  endtask

  task automatic single_c(input logic [7:0] d, input logic dc, input string tag);
    @(negedge clk_50M);
    c_q.push_back({d, dc, 1'b1});
    wait_idle(tag);
    check_eq({tag, "_ack_latency"}, 32'(c_ack_cyc - c_rise_cyc), 32'd1);
    check_eq({tag, "_wr_latency"}, 32'(wr_cyc - c_rise_cyc), 32'(DC_SETUP + 2));
    check_eq({tag, "_spi_data"}, 32'(spi_data), 32'(d));
    check_eq({tag, "_oled_dc"}, 32'(oled_dc), 32'(dc));
    check_eq({tag, "_grant_released"}, 32'(grant), 32'd0);
  endtask

  initial begin
    int e0, w0;
    n_chk = 0; n_fail = 0; hang = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk_50M);
    #1;
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_spi_wr", 32'(spi_wr), 32'd0);
    check_eq("rst_spi_data", 32'(spi_data), 32'd0);
    check_eq("rst_oled_dc", 32'(oled_dc), 32'd0);
    @(negedge clk_50M) rst_n = 1'b1;

    single_c(8'hAE, 1'b0, "t1");

    gl.delete();
    @(negedge clk_50M);
    c_q.push_back({8'h01, 1'b0, 1'b0});
    c_q.push_back({8'h02, 1'b0, 1'b0});
    c_q.push_back({8'h03, 1'b0, 1'b1});
    p_q.push_back({8'h80, 1'b1, 1'b1});
    wait_idle("t2");
    check_grants("t2", "CCCP");

    gl.delete();
    @(negedge clk_50M);
    for (int i = 0; i < 6; i++) c_q.push_back({8'(8'h30 + i), 1'b0, 1'b1});
    p_q.push_back({8'h90, 1'b1, 1'b0});
    p_q.push_back({8'h91, 1'b1, 1'b1});
    p_q.push_back({8'h92, 1'b1, 1'b1});
    wait_idle("t3");
    check_grants("t3", "CCCCPPCCP");

    gl.delete();
    @(negedge clk_50M);
    c_q.push_back({8'h21, 1'b0, 1'b1});
    p_q.push_back({8'hFF, 1'b1, 1'b1});
    wait_idle("t4");
    check_grants("t4", "CP");
    check_eq("t4_final_dc", 32'(oled_dc), 32'd1);
    check_eq("t4_final_data", 32'(spi_data), 32'hFF);

    gl.delete();
    e0 = err_cnt;
    @(negedge clk_50M);
    c_q.push_back({8'h10, 1'b1, 1'b0});
    repeat (2 * TIMEOUT) @(negedge clk_50M);
    check_eq("t5_busy_in_wait_req", 32'(busy), 32'd1);
    check_eq("t5_grant_held", 32'(grant), 32'd1);
    c_q.push_back({8'h11, 1'b1, 1'b1});
    wait_idle("t5");
    check_eq("t5_no_timeout", 32'(err_cnt - e0), 32'd0);
    check_grants("t5", "CC");

    hang = 1'b1;
    e0 = err_cnt;
    @(negedge clk_50M);
    c_q.push_back({8'h55, 1'b0, 1'b1});
    for (int i = 0; i < 3 * int'(TIMEOUT) && err_cnt == e0; i++) @(negedge clk_50M);
    check_eq("t6_err_seen", 32'(err_cnt - e0), 32'd1);
    check_eq("t6_err_latency", 32'(err_cyc - wr_cyc), 32'(TIMEOUT));
    @(posedge clk_50M); #1;
    check_eq("t6_err_pulse", 32'(err), 32'd0);
    check_eq("t6_grant", 32'(grant), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    hang = 1'b0;
    single_c(8'h5A, 1'b1, "t6b");

    hang = 1'b1;
    w0 = wr_n;
    @(negedge clk_50M);
    c_q.push_back({8'hC3, 1'b1, 1'b1});
    for (int i = 0; i < 50 && wr_n == w0; i++) @(negedge clk_50M);
    check_eq("t7_write_seen", 32'(wr_n - w0), 32'd1);
    repeat (3) @(negedge clk_50M);
    check_eq("t7_in_wait", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t7_rst_grant", 32'(grant), 32'd0);
    check_eq("t7_rst_busy", 32'(busy), 32'd0);
    check_eq("t7_rst_spi_data", 32'(spi_data), 32'd0);
    check_eq("t7_rst_oled_dc", 32'(oled_dc), 32'd0);
    check_eq("t7_rst_err", 32'(err), 32'd0);
    @(negedge clk_50M);
    @(negedge clk_50M) rst_n = 1'b1;
    hang = 1'b0;
    single_c(8'h3C, 1'b0, "t7b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
